// File: rtl/ifu_axi_fetch.sv
// Purpose : instruction-fetch bus master; one single-beat read at a time, picks a 32-bit instruction out of the 64-bit word.
// Latency : request accepted in cycle N -> inst_valid in N+3 at best (ar/r stalls add cycle for cycle).
// Backpr. : req_ready low while a fetch is in flight; inst/inst_pc held stable while inst_ready is low.
//
// Ports:
//   clk, reset         - single clock, asynchronous active-low reset
//   req_valid/ready    - fetch address from the PC stage (req_addr)
//   flush              - cancels a pending or in-flight fetch; the bus handshake is always completed
//   inst_valid/ready   - instruction (inst, inst_pc, inst_err) to the decode stage
//   ar_valid/ready     - read address channel (araddr) to the SRAM
//   r_valid/ready      - read data channel (rdata) from the SRAM
//
// Optional feature: define IFU_ALIGN_CHECK_EN to reject fetch addresses with addr[1:0] != 0.
// Such a fetch returns inst = 0, inst_err = 1 one cycle after acceptance and never touches the bus.
// Without it the low address bits are ignored by the selection logic and inst_err stays 0.

module ifu_axi_fetch #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [63:0]       rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q;
    logic                drop_q;      // current transaction was flushed; its data beat is discarded
    logic [ADDR_W-1:0]   pc_q;
    logic [INST_W-1:0]   inst_q;
    logic                inst_err_q;
    logic                ar_valid_q;
    logic                r_ready_q;
    logic                inst_valid_q;

    // The only combinational path to an output: a flush blocks acceptance in the same cycle.
    assign req_ready  = reset && (state_q == S_IDLE) && !flush;

    assign ar_valid   = ar_valid_q;
    assign araddr     = pc_q;
    assign r_ready    = r_ready_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = pc_q;
    assign inst_err   = inst_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            drop_q       <= 1'b0;
            pc_q         <= '0;
            inst_q       <= '0;
            inst_err_q   <= 1'b0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        pc_q   <= req_addr;
                        drop_q <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
                        if (req_addr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error straight away, no bus access.
                            inst_q       <= '0;
                            inst_err_q   <= 1'b1;
                            inst_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= S_ADDR;
                        end
`else
                        ar_valid_q <= 1'b1;
                        state_q    <= S_ADDR;
`endif
                    end
                end

                S_ADDR: begin
                    // A flush cannot withdraw ar_valid; it only marks the beat for discard.
                    if (flush) begin
                        drop_q <= 1'b1;
                    end
                    if (ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (r_valid) begin
                        r_ready_q <= 1'b0;
                        if (drop_q || flush) begin
                            state_q <= S_IDLE;
                        end else begin
                            inst_q       <= pc_q[2] ? INST_W'(rdata[63:32]) : INST_W'(rdata[31:0]);
                            inst_err_q   <= 1'b0;
                            inst_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end

                S_RESP: begin
                    // Flush wins over inst_ready: the held instruction is dropped.
                    if (flush || inst_ready) begin
                        inst_valid_q <= 1'b0;
                        inst_err_q   <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
